life_manager: RTL and testbench

// - Owns the player's life count; produces the life value and consumes start/gameEnd

---
 rtl/life_manager.sv | 218 +++++++++++++++++++++
 tb/tb_life_manager.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/life_manager.sv
// Player life counter with drain/respawn/relaunch sequencing and bonus lives.
// Optional ball-save window after each launch when LIFE_GRACE_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no game; life held at INIT_LIVES, waiting for a start rise
// LAUNCH  | one-cycle ballLaunch pulse, ball placed at the plunger
// PLAY    | ball in play; drains cost a life (unless ball-save is open)
// RESPAWN | ball drained, counting frameTicks until the next launch
// OVER    | game over; life held at 0 until start falls
module life_manager #(
    parameter int unsigned INIT_LIVES     = 3,
    parameter int unsigned MAX_LIVES      = 9,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned GRACE_FRAMES   = 120
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       frameTick_i,
    input  logic       start_i,
    input  logic       gameEnd_i,
    input  logic       ballLost_i,
    input  logic       extraLife_i,
    output logic [3:0] life_o,
    output logic       ballLaunch_o,
    output logic       respawnPending_o,
    output logic       ballSaveActive_o
);

    // One frame counter is shared by the respawn delay and the ball-save window.
    localparam int unsigned CNT_MAX = (RESPAWN_FRAMES > GRACE_FRAMES) ? RESPAWN_FRAMES : GRACE_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0]       INIT_L    = 4'(INIT_LIVES);
    localparam logic [3:0]       MAX_L     = 4'(MAX_LIVES);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESPAWN_FRAMES - 1);
`ifdef LIFE_GRACE_EN
    localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE_FRAMES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_PLAY,
        S_RESPAWN,
        S_OVER
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       life_q, life_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic [3:0]       life_inc;
`ifdef LIFE_GRACE_EN
    logic             save_q, save_d;
`endif

    assign life_inc = (life_q >= MAX_L) ? MAX_L : life_q + 4'd1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            life_q  <= INIT_L;
            cnt_q   <= '0;
            start_q <= 1'b0;
`ifdef LIFE_GRACE_EN
            save_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            life_q  <= life_d;
            cnt_q   <= cnt_d;
            start_q <= start_i;
`ifdef LIFE_GRACE_EN
            save_q  <= save_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        life_d  = life_q;
        cnt_d   = cnt_q;
`ifdef LIFE_GRACE_EN
        save_d  = save_q;
`endif
        if (!start_i) begin
            // Abort from anywhere, including game-over acknowledge.
            state_d = S_IDLE;
            life_d  = INIT_L;
            cnt_d   = '0;
`ifdef LIFE_GRACE_EN
            save_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    life_d = INIT_L;
                    cnt_d  = '0;
                    if (!start_q) begin
                        state_d = S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    if (gameEnd_i) begin
                        state_d = S_OVER;
                        life_d  = 4'd0;
                        cnt_d   = '0;
`ifdef LIFE_GRACE_EN
                        save_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
`ifdef LIFE_GRACE_EN
                        save_d  = 1'b1;
`endif
                        if (extraLife_i) begin
                            life_d = life_inc;
                        end
                    end
                end

                S_PLAY: begin
                    if (gameEnd_i) begin
                        state_d = S_OVER;
                        life_d  = 4'd0;
                        cnt_d   = '0;
`ifdef LIFE_GRACE_EN
                        save_d  = 1'b0;
`endif
                    end else begin
`ifdef LIFE_GRACE_EN
                        if (save_q && frameTick_i) begin
                            cnt_d = cnt_q + CNT_W'(1);
                            if (cnt_q == GRACE_LAST) begin
                                save_d = 1'b0;
                            end
                        end
                        if (ballLost_i && save_q) begin
                            // Saved drain: free immediate relaunch, window restarts in LAUNCH.
                            state_d = S_LAUNCH;
                            if (extraLife_i) begin
                                life_d = life_inc;
                            end
                        end else
`endif
                        if (ballLost_i) begin
`ifdef LIFE_GRACE_EN
                            save_d = 1'b0;
`endif
                            if (extraLife_i) begin
                                // Bonus cancels the drain; always a respawn, never game over.
                                state_d = S_RESPAWN;
                                cnt_d   = '0;
                            end else begin
                                life_d = life_q - 4'd1;
                                if (life_q == 4'd1) begin
                                    state_d = S_OVER;
                                end else begin
                                    state_d = S_RESPAWN;
                                    cnt_d   = '0;
                                end
                            end
                        end else if (extraLife_i) begin
                            life_d = life_inc;
                        end
                    end
                end

                S_RESPAWN: begin
                    if (gameEnd_i) begin
                        state_d = S_OVER;
                        life_d  = 4'd0;
                        cnt_d   = '0;
                    end else begin
                        if (extraLife_i) begin
                            life_d = life_inc;
                        end
                        if (frameTick_i) begin
                            if (cnt_q == RESP_LAST) begin
                                state_d = S_LAUNCH;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end

                S_OVER: begin
                    life_d = 4'd0;
                end

                default: begin
                    state_d = S_IDLE;
                    life_d  = INIT_L;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign life_o           = life_q;
    assign ballLaunch_o     = (state_q == S_LAUNCH);
    assign respawnPending_o = (state_q == S_RESPAWN);
`ifdef LIFE_GRACE_EN
    assign ballSaveActive_o = save_q;
`else
    assign ballSaveActive_o = 1'b0;
`endif

    a_life_max: assert property (@(posedge clk) disable iff (!resetN) life_q <= MAX_L);
    a_over_zero: assert property (@(posedge clk) disable iff (!resetN)
                                  (state_q == S_OVER) |-> (life_q == 4'd0));

endmodule

// File: tb/tb_life_manager.sv
// Randomized scoreboard bench for life_manager: a game-level model predicts each
// cycle's outputs into a queue, and a monitor pops and compares after every edge.
module tb_life_manager;

    localparam int INIT   = 3;
    localparam int MAX    = 9;
    localparam int RESP   = 60;
    localparam int GRACE  = 120;

    logic       clk = 1'b0;
    logic       resetN;
    logic       frameTick, start, gameEnd, ballLost, extraLife;
    logic [3:0] life;
    logic       ballLaunch, respawnPending, ballSaveActive;

    life_manager #(
        .INIT_LIVES    (INIT),
        .MAX_LIVES     (MAX),
        .RESPAWN_FRAMES(RESP),
        .GRACE_FRAMES  (GRACE)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .frameTick_i     (frameTick),
        .start_i         (start),
        .gameEnd_i       (gameEnd),
        .ballLost_i      (ballLost),
        .extraLife_i     (extraLife),
        .life_o          (life),
        .ballLaunch_o    (ballLaunch),
        .respawnPending_o(respawnPending),
        .ballSaveActive_o(ballSaveActive)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] life;
        logic       launch;
        logic       pending;
        logic       save;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    // Game-level reference: lives, whether a launch happens, ball in play,
    // waiting for a relaunch (with frames seen), game over, frames of ball-save left.
    int m_lives, m_frames, m_save;
    bit m_prev_start, m_launch, m_play, m_wait, m_over;

    task automatic model_step();
        int plus;
        bit saved;
        if (!resetN) begin
            m_lives = INIT; m_frames = 0; m_save = 0;
            m_prev_start = 0; m_launch = 0; m_play = 0; m_wait = 0; m_over = 0;
        end else begin
            plus = (m_lives + 1 > MAX) ? MAX : m_lives + 1;
            if (!start) begin
                m_lives = INIT; m_frames = 0; m_save = 0;
                m_launch = 0; m_play = 0; m_wait = 0; m_over = 0;
            end else if (m_over) begin
                m_lives = 0;
            end else if (!(m_launch || m_play || m_wait)) begin
                if (!m_prev_start) begin
                    m_launch = 1;
                    m_lives  = INIT;
                end
            end else if (gameEnd) begin
                m_over = 1; m_lives = 0; m_save = 0;
                m_launch = 0; m_play = 0; m_wait = 0;
            end else if (m_launch) begin
                m_launch = 0;
                m_play   = 1;
                if (extraLife) m_lives = plus;
`ifdef LIFE_GRACE_EN
                m_save = GRACE;
`endif
            end else if (m_play) begin
                saved = (m_save > 0);
                if (frameTick && m_save > 0) m_save--;
                if (ballLost) begin
                    m_play = 0;
                    if (saved) begin
                        m_launch = 1;
                        if (extraLife) m_lives = plus;
                    end else begin
                        m_save = 0;
                        if (extraLife) begin
                            m_wait = 1; m_frames = 0;
                        end else begin
                            m_lives--;
                            if (m_lives == 0) m_over = 1;
                            else begin m_wait = 1; m_frames = 0; end
                        end
                    end
                end else if (extraLife) begin
                    m_lives = plus;
                end
            end else begin
                if (extraLife) m_lives = plus;
                if (frameTick) begin
                    m_frames++;
                    if (m_frames == RESP) begin
                        m_wait   = 0;
                        m_launch = 1;
                    end
                end
            end
            m_prev_start = start;
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.life    = 4'(m_lives);
        e.launch  = m_launch;
        e.pending = m_wait;
        e.save    = (m_save > 0);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic cyc(input bit ft, input bit bl, input bit el);
        frameTick = ft; ballLost = bl; extraLife = el;
        tick();
        frameTick = 0; ballLost = 0; extraLife = 0;
    endtask

    task automatic drain_and_relaunch();
        cyc(0, 1, 0);
        repeat (RESP) cyc(1, 0, 0);
        repeat (2) cyc(0, 0, 0);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("life",           life,                  mon_e.life);
            check("ballLaunch",     {3'b0, ballLaunch},     {3'b0, mon_e.launch});
            check("respawnPending", {3'b0, respawnPending}, {3'b0, mon_e.pending});
            check("ballSaveActive", {3'b0, ballSaveActive}, {3'b0, mon_e.save});
        end
    end

    initial begin
        int r;
        resetN = 0; start = 0; gameEnd = 0;
        frameTick = 0; ballLost = 0; extraLife = 0;
        repeat (3) cyc(0, 0, 0);
        resetN = 1;
        repeat (2) cyc(0, 0, 0);

        // Start, one drain with full respawn, then bonus-life saturation.
        start = 1;
        repeat (3) cyc(0, 0, 0);
        drain_and_relaunch();
        repeat (10) cyc(0, 0, 1);
        repeat (2) cyc(0, 0, 0);

        // Abort, restart, drain to game over, acknowledge via gameEnd + start fall.
        start = 0;
        repeat (2) cyc(0, 0, 0);
        start = 1;
        repeat (3) cyc(0, 0, 0);
        repeat (3) drain_and_relaunch();
        cyc(0, 1, 1);
        gameEnd = 1;
        repeat (3) cyc(0, 0, 0);
        start = 0;
        repeat (2) cyc(0, 0, 0);
        gameEnd = 0;

        // Reach life=1, then simultaneous drain+bonus, then abort mid-respawn.
        start = 1;
        repeat (3) cyc(0, 0, 0);
        repeat (2) drain_and_relaunch();
        cyc(0, 1, 1);
        repeat (5) cyc(1, 0, 0);
        start = 0;
        repeat (3) cyc(0, 0, 0);

        for (int i = 0; i < 12000; i++) begin
            r = $urandom_range(0, 999);
            if (!start) begin
                if (r < 40) start = 1;
            end else if (m_over && !gameEnd) begin
                if (r < 100) gameEnd = 1;
            end else if (gameEnd && r < 30) begin
                start = 0; gameEnd = 0;
            end else if (r < 2) begin
                start = 0; gameEnd = 0;
            end else if (r < 4) begin
                gameEnd = 1;
            end
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0);
        end

        @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
